// File: rtl/ne555_mono_pkg.sv
// Shared definitions for the ne555_mono monostable timer slice.
package ne555_mono_pkg;

    localparam int DUR_W_DEF = 16;

endpackage

// File: rtl/ne555_mono_if.sv
// Pin-level bundle of the 555 monostable: timebase enable, trigger/reset pins, width and outputs.
interface ne555_mono_if
    import ne555_mono_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEF
);

    logic             ce;
    logic             trig_n;
    logic             rst_n;
    logic [DUR_W-1:0] dur;
    logic             q;
    logic             done;

    modport master (
        output ce, trig_n, rst_n, dur,
        input  q, done
    );

    modport slave (
        input  ce, trig_n, rst_n, dur,
        output q, done
    );

endinterface

// File: rtl/ne555_mono_ttl_downcnt.sv
// Loadable down-counter with clock enable, synchronous clear and a zero flag.
module ttl_downcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         ce_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Decrement saturates at zero so a held count never wraps.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (ce_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/ne555_mono.sv
// 555 timer in monostable mode: non-retriggerable pulse of max(dur,1) ce ticks, held while trigger stays low.
module ne555_mono
    import ne555_mono_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ne555_mono_if.slave    io
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TIMING = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t           state_q;
    logic             q_q;
    logic             done_q;
    logic             accept;
    logic             cnt_zero;
    logic [DUR_W-1:0] cnt_val;
    logic [DUR_W-1:0] load_val;

    assign accept   = (state_q == ST_IDLE) && io.ce && !io.trig_n && io.rst_n;
    // A zero width behaves like one tick.
    assign load_val = (io.dur == '0) ? '0 : io.dur - DUR_W'(1);

    ttl_downcnt #(.W(DUR_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!io.rst_n),
        .load_i    (accept),
        .load_val_i(load_val),
        .ce_i      (io.ce && (state_q == ST_TIMING)),
        .count_o   (cnt_val),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!io.rst_n) begin
                state_q <= ST_IDLE;
                q_q     <= 1'b0;
            end else if (io.ce) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!io.trig_n) begin
                            state_q <= ST_TIMING;
                            q_q     <= 1'b1;
                        end
                    end
                    ST_TIMING: begin
                        if (cnt_zero) begin
                            if (io.trig_n) begin
                                state_q <= ST_IDLE;
                                q_q     <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (io.trig_n) begin
                            state_q <= ST_IDLE;
                            q_q     <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        q_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.q    = q_q;
    assign io.done = done_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_ne555_mono.sv
// Self-checking bench for ne555_mono: tick-counting pulse model compared every cycle, plus literal pulse widths.
module tb_ne555_mono;

    localparam int DUR_W = 16;

    logic clk = 1'b0;
    logic reset;

    ne555_mono_if #(.DUR_W(DUR_W)) bus ();

    ne555_mono #(.DUR_W(DUR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ce_period = 1;
    int cyc = 0;
    bit checking = 1'b0;

    // Counts of DUT activity since the last clear_meas
    int q_hi = 0;
    int done_cnt = 0;

    // Model: a pulse lasts until at least `width` ce ticks have passed since acceptance and trigger is high.
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    int m_ticks = 0;
    int m_width = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (reset || !bus.rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (bus.ce) begin
                if (!m_active) begin
                    if (!bus.trig_n) begin
                        m_active = 1'b1;
                        m_ticks  = 0;
                        m_width  = (bus.dur == 0) ? 1 : int'(bus.dur);
                    end
                end else begin
                    m_ticks++;
                    if (m_ticks >= m_width && bus.trig_n) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("q_vs_model", 32'(bus.q), 32'(m_active));
            check("done_vs_model", 32'(bus.done), 32'(m_done));
            if (bus.q === 1'b1) q_hi++;
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            bus.ce = (ce_period == 1) ? 1'b1 : ((cyc % ce_period) == 0);
        end
    endtask

    task automatic clear_meas();
        q_hi = 0;
        done_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.ce = 1'b1;
        bus.trig_n = 1'b1;
        bus.rst_n = 1'b1;
        bus.dur = 16'd5;
        step(2);
        checking = 1'b1;
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        step(2);

        // 1: basic pulse
        clear_meas();
        bus.dur = 16'd5;
        bus.trig_n = 1'b0;
        step();
        check("t1_q_rises", 32'(bus.q), 32'd1);
        bus.trig_n = 1'b1;
        step(10);
        check("t1_width", 32'(q_hi), 32'd5);
        check("t1_done", 32'(done_cnt), 32'd1);

        // 2: ce every 4th clock, trigger held across one ce
        ce_period = 4;
        step(4);
        clear_meas();
        bus.dur = 16'd3;
        bus.trig_n = 1'b0;
        step(4);
        bus.trig_n = 1'b1;
        step(24);
        check("t2_width", 32'(q_hi), 32'd12);
        check("t2_done", 32'(done_cnt), 32'd1);
        ce_period = 1;
        step(2);

        // 3: non-retriggerable, dur latched at acceptance
        clear_meas();
        bus.dur = 16'd10;
        bus.trig_n = 1'b0;
        step();
        bus.trig_n = 1'b1;
        step(3);
        bus.trig_n = 1'b0;
        step();
        bus.trig_n = 1'b1;
        bus.dur = 16'd2;
        step(12);
        check("t3_width", 32'(q_hi), 32'd10);
        check("t3_done", 32'(done_cnt), 32'd1);

        // 4: trigger held low past expiry
        clear_meas();
        bus.dur = 16'd4;
        bus.trig_n = 1'b0;
        step(9);
        check("t4_hold_q", 32'(bus.q), 32'd1);
        check("t4_hold_nodone", 32'(done_cnt), 32'd0);
        bus.trig_n = 1'b1;
        step(5);
        check("t4_width", 32'(q_hi), 32'd9);
        check("t4_done", 32'(done_cnt), 32'd1);

        // 5: chip reset abort, then restart while trigger still low
        clear_meas();
        bus.dur = 16'd20;
        bus.trig_n = 1'b0;
        step(7);
        bus.rst_n = 1'b0;
        step();
        check("t5_abort_q", 32'(bus.q), 32'd0);
        step(3);
        check("t5_abort_width", 32'(q_hi), 32'd7);
        check("t5_abort_nodone", 32'(done_cnt), 32'd0);
        clear_meas();
        bus.rst_n = 1'b1;
        step();
        check("t5_restart_q", 32'(bus.q), 32'd1);
        bus.trig_n = 1'b1;
        step(30);
        check("t5_restart_width", 32'(q_hi), 32'd20);
        check("t5_restart_done", 32'(done_cnt), 32'd1);

        // 6a: dur=0 acts as 1
        clear_meas();
        bus.dur = 16'd0;
        bus.trig_n = 1'b0;
        step();
        bus.trig_n = 1'b1;
        step(5);
        check("t6_dur0_width", 32'(q_hi), 32'd1);
        check("t6_dur0_done", 32'(done_cnt), 32'd1);

        // 6b: system reset mid-pulse
        clear_meas();
        bus.dur = 16'd50;
        bus.trig_n = 1'b0;
        step();
        bus.trig_n = 1'b1;
        step(5);
        reset = 1'b1;
        step();
        check("t6_reset_q", 32'(bus.q), 32'd0);
        check("t6_reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        step(3);
        check("t6_reset_nodone", 32'(done_cnt), 32'd0);

        // 6c: full-scale width, no wrap
        clear_meas();
        bus.dur = 16'hFFFF;
        bus.trig_n = 1'b0;
        step();
        bus.trig_n = 1'b1;
        step(65540);
        check("t6_max_width", 32'(q_hi), 32'd65535);
        check("t6_max_done", 32'(done_cnt), 32'd1);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
